// File: rtl/cd_sector_responder_pkg.sv
// Shared types and constants for the CD sector responder.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cd_responder_pkg;

  // Raw CD sector: 2352 bytes = 1176 sixteen-bit words
  localparam int SECTOR_WORDS_RAW = 1176;

  typedef enum logic [2:0] {
    IDLE,
    UP_REQ,
    XFER,
    PAD,
    DONE
  } state_t;

endpackage

// File: rtl/cd_sector_responder_if.sv
// Bundles the CDIC sector-request side, the HPS storage side and the status flags.
// Latency: none (wires only).
// Backpressure: none; the HPS side cannot be stalled, so overflow is reported instead.
interface cd_sector_responder_if;
  logic        cd_img_mounted;
  logic [31:0] cd_hps_lba;
  logic        cd_hps_req;
  logic        cd_hps_ack;
  logic        cd_hps_data_valid;
  logic [15:0] cd_hps_data;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic        err_overflow;
  logic        err_underrun;
  logic        req_dropped;

  // Environment view: CDIC initiator plus HPS storage
  modport master (
    output cd_img_mounted, cd_hps_lba, cd_hps_req, sd_ack, sd_buff_wr, sd_buff_dout,
    input  cd_hps_ack, cd_hps_data_valid, cd_hps_data, sd_lba, sd_rd,
           err_overflow, err_underrun, req_dropped
  );

  // Responder view
  modport slave (
    input  cd_img_mounted, cd_hps_lba, cd_hps_req, sd_ack, sd_buff_wr, sd_buff_dout,
    output cd_hps_ack, cd_hps_data_valid, cd_hps_data, sd_lba, sd_rd,
           err_overflow, err_underrun, req_dropped
  );
endinterface

// File: rtl/cd_sector_responder_fifo.sv
// First-word-fall-through 16-bit FIFO with extra pointer bit for full/empty.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: none internally; the caller must gate push with full (push+pop on full is legal).
module sync_fifo_w16 #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; wraps naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cd_sector_responder.sv
// Answers CDIC sector requests by reading the HPS and streaming one raw sector of paced words.
// Latency: req->sd_rd 1 cycle; sd_ack seen->cd_hps_ack 1 cycle; sd_buff_wr->first valid 2 cycles.
// Backpressure: none upstream; excess or FIFO-full words are dropped and flagged, short sectors are zero-padded.
module cd_sector_responder
  import cd_responder_pkg::*;
#(
  parameter int SECTOR_WORDS = SECTOR_WORDS_RAW,
  parameter int FIFO_DEPTH   = 16,
  parameter int PACE         = 4
) (
  input logic                  clk30,
  input logic                  reset_n,
  cd_sector_responder_if.slave bus
);
  localparam int CW = $clog2(SECTOR_WORDS + 1);
  localparam int PW = $clog2(PACE + 1);
  localparam logic [CW-1:0] SW_ALL  = CW'(SECTOR_WORDS);
  localparam logic [CW-1:0] SW_LAST = CW'(SECTOR_WORDS - 1);
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [PW-1:0] pace;
  logic          aborted;
  logic          ack_q;
  logic          wr_q;
  logic [15:0]   din_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_dout;
  logic          push;
  logic          pop;
  logic          pad_emit;
  logic          drop_word;
  logic          ack_fall;
  logic          in_short;

  // Ingress/egress decisions for this cycle
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    drop_word = 1'b0;
    pad_emit  = 1'b0;
    ack_fall  = ack_q && !bus.sd_ack;
    pop       = (state == XFER) && !fifo_empty && (pace == '0);
    push      = (state == XFER) && wr_q && !aborted && (in_cnt < SW_ALL) && (!fifo_full || pop);
    drop_word = (state == XFER) && wr_q && !push;
    pad_emit  = (state == PAD) && (pace == '0) && (out_cnt < SW_ALL);
    in_short  = (in_cnt + CW'(push)) < SW_ALL;
  end

  // Register upstream strobe/data and sd_ack for edge detection
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      wr_q  <= 1'b0;
      din_q <= '0;
    end else begin
      ack_q <= bus.sd_ack;
      wr_q  <= bus.sd_buff_wr;
      din_q <= bus.sd_buff_dout;
    end
  end

  sync_fifo_w16 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk30),
    .rst_n (reset_n),
    .push  (push),
    .din   (din_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request FSM with registered outputs, counters and sticky flags
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      in_cnt                <= '0;
      out_cnt               <= '0;
      pace                  <= '0;
      aborted               <= 1'b0;
      bus.cd_hps_ack        <= 1'b0;
      bus.cd_hps_data_valid <= 1'b0;
      bus.cd_hps_data       <= '0;
      bus.sd_lba            <= '0;
      bus.sd_rd             <= 1'b0;
      bus.err_overflow      <= 1'b0;
      bus.err_underrun      <= 1'b0;
      bus.req_dropped       <= 1'b0;
    end else begin
      bus.cd_hps_ack        <= 1'b0;
      bus.cd_hps_data_valid <= 1'b0;

      if (bus.cd_hps_req && (state != IDLE)) bus.req_dropped <= 1'b1;
      if (drop_word) bus.err_overflow <= 1'b1;
      if (push) in_cnt <= in_cnt + 1'b1;

      // One word out per pace window: FIFO data in XFER, zeros in PAD
      if (pop || pad_emit) begin
        bus.cd_hps_data_valid <= 1'b1;
        bus.cd_hps_data       <= pop ? fifo_dout : 16'h0000;
        out_cnt               <= out_cnt + 1'b1;
        pace                  <= PACE_RELOAD;
      end else if (pace != '0) begin
        pace <= pace - PW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.cd_hps_req) begin
            bus.sd_lba <= bus.cd_hps_lba;
            in_cnt     <= '0;
            out_cnt    <= '0;
            pace       <= '0;
            aborted    <= 1'b0;
            if (bus.cd_img_mounted) begin
              state     <= UP_REQ;
              bus.sd_rd <= 1'b1;
            end else begin
              state          <= PAD;
              bus.cd_hps_ack <= 1'b1;
            end
          end
        end
        UP_REQ: begin
          if (bus.sd_ack) begin
            bus.sd_rd      <= 1'b0;
            bus.cd_hps_ack <= 1'b1;
            state          <= XFER;
          end
        end
        XFER: begin
          // Upstream quit early: flag it, drain what we have, then pad
          if (ack_fall && in_short) begin
            bus.err_underrun <= 1'b1;
            aborted          <= 1'b1;
          end
          if ((aborted || (ack_fall && in_short)) && fifo_empty && !push) state <= PAD;
        end
        PAD: ;
        DONE: begin
          if (!bus.sd_ack || !bus.cd_img_mounted) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Last sector word leaves: wait for the HPS to release
      if ((pop || pad_emit) && (out_cnt == SW_LAST)) state <= DONE;
    end
  end
endmodule

// File: tb/tb_cd_sector_responder.sv
// Directed bench for cd_sector_responder: mounted, unmounted, underrun, dropped req, overflow, reset.
// Latency: checks req->sd_rd, sd_ack->cd_hps_ack and exact 4-cycle word spacing.
// Backpressure: upstream model paces itself to the output rate except where overflow is intended.
module tb_cd_sector_responder;
  localparam int SW   = 1176;
  localparam int PACE = 4;

  logic clk30 = 1'b0;
  logic reset_n;
  always #5 clk30 = ~clk30;

  cd_sector_responder_if bus_if ();

  cd_sector_responder #(.SECTOR_WORDS(SW), .FIFO_DEPTH(16), .PACE(PACE)) dut (
    .clk30   (clk30),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Expected stream description, written only by the stimulus block
  int   exp_base = 0;
  int   n_data   = 0;
  int   data_off = 0;
  logic gap_chk  = 1'b0;

  // Monitor state, written only by the monitor
  int   vtot = 0, mism = 0, gap_bad = 0, acks = 0, rd_rises = 0, since = 0;
  logic rd_q = 1'b0;

  int rd0, ack0, mism0, gap0;

  // Sample DUT outputs on the falling edge and compare each word to the expected stream
  always @(negedge clk30) begin
    int idx;
    logic [15:0] expd;
    if (bus_if.cd_hps_ack === 1'b1) acks++;
    if (bus_if.sd_rd === 1'b1 && rd_q !== 1'b1) rd_rises++;
    rd_q = bus_if.sd_rd;
    since++;
    if (bus_if.cd_hps_data_valid === 1'b1) begin
      idx  = vtot - exp_base;
      expd = (idx < n_data) ? 16'(data_off + idx) : 16'h0000;
      if (bus_if.cd_hps_data !== expd) mism++;
      if (gap_chk && idx > 0 && since != PACE) gap_bad++;
      since = 0;
      vtot++;
    end
  end

  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic begin_txn(input int lba, input logic mnt, input int nd, input int off, input logic gchk);
    exp_base = vtot;
    n_data   = nd;
    data_off = off;
    gap_chk  = gchk;
    rd0      = rd_rises;
    ack0     = acks;
    mism0    = mism;
    gap0     = gap_bad;
    bus_if.cd_img_mounted = mnt;
    bus_if.cd_hps_lba     = 32'(lba);
    bus_if.cd_hps_req     = 1'b1;
    tick();
    bus_if.cd_hps_req     = 1'b0;
  endtask

  task automatic send(input int n, input int off, input int gap);
    for (int i = 0; i < n; i++) begin
      bus_if.sd_buff_wr   = 1'b1;
      bus_if.sd_buff_dout = 16'(off + i);
      tick();
      bus_if.sd_buff_wr   = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic finish_txn(input string tag, input int budget);
    int k = 0;
    while ((vtot - exp_base) < SW && k < budget) begin
      tick();
      k++;
    end
    repeat (20) tick();
    check({tag, "_total"}, 32'(vtot - exp_base), 32'(SW));
    check({tag, "_data"}, 32'(mism - mism0), 32'd0);
    check({tag, "_gap"}, 32'(gap_bad - gap0), 32'd0);
  endtask

  initial begin
    reset_n               = 1'b0;
    bus_if.cd_img_mounted = 1'b0;
    bus_if.cd_hps_lba     = '0;
    bus_if.cd_hps_req     = 1'b0;
    bus_if.sd_ack         = 1'b0;
    bus_if.sd_buff_wr     = 1'b0;
    bus_if.sd_buff_dout   = '0;
    repeat (3) tick();
    check("rst_valid", 32'(bus_if.cd_hps_data_valid), 32'd0);
    check("rst_ack", 32'(bus_if.cd_hps_ack), 32'd0);
    check("rst_sd_rd", 32'(bus_if.sd_rd), 32'd0);
    check("rst_flags", 32'({bus_if.err_overflow, bus_if.err_underrun, bus_if.req_dropped}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Mounted, full clean sector with incrementing data
    begin_txn(32'h10, 1'b1, SW, 0, 1'b1);
    check("t1_sd_rd", 32'(bus_if.sd_rd), 32'd1);
    check("t1_sd_lba", bus_if.sd_lba, 32'h10);
    repeat (4) tick();
    check("t1_rd_held", 32'(bus_if.sd_rd), 32'd1);
    bus_if.sd_ack = 1'b1;
    tick();
    check("t1_ack", 32'(bus_if.cd_hps_ack), 32'd1);
    check("t1_rd_drop", 32'(bus_if.sd_rd), 32'd0);
    tick();
    check("t1_ack_single", 32'(bus_if.cd_hps_ack), 32'd0);
    send(SW, 0, PACE);
    bus_if.sd_ack = 1'b0;
    finish_txn("t1", 100);
    check("t1_ack_cnt", 32'(acks - ack0), 32'd1);
    check("t1_flags", 32'({bus_if.err_overflow, bus_if.err_underrun, bus_if.req_dropped}), 32'd0);

    // Unmounted: immediate ack, zero sector, no upstream read
    begin_txn(32'h20, 1'b0, 0, 0, 1'b1);
    check("t2_ack", 32'(bus_if.cd_hps_ack), 32'd1);
    check("t2_sd_rd", 32'(bus_if.sd_rd), 32'd0);
    check("t2_sd_lba", bus_if.sd_lba, 32'h20);
    finish_txn("t2", SW * PACE + 50);
    check("t2_no_rd", 32'(rd_rises - rd0), 32'd0);
    check("t2_ack_cnt", 32'(acks - ack0), 32'd1);

    // Upstream gives up after 100 words: data then zero padding
    begin_txn(32'h30, 1'b1, 100, 32'h1000, 1'b0);
    tick();
    bus_if.sd_ack = 1'b1;
    tick();
    send(100, 32'h1000, PACE);
    bus_if.sd_ack = 1'b0;
    finish_txn("t3", SW * PACE + 100);
    check("t3_underrun", 32'(bus_if.err_underrun), 32'd1);
    check("t3_overflow", 32'(bus_if.err_overflow), 32'd0);

    // Second request mid-transfer is dropped and does not disturb the sector
    begin_txn(32'h40, 1'b1, SW, 32'h2000, 1'b0);
    tick();
    bus_if.sd_ack = 1'b1;
    tick();
    send(200, 32'h2000, PACE);
    check("t5_drop_before", 32'(bus_if.req_dropped), 32'd0);
    bus_if.cd_hps_lba = 32'h99;
    bus_if.cd_hps_req = 1'b1;
    tick();
    bus_if.cd_hps_req = 1'b0;
    tick();
    check("t5_dropped", 32'(bus_if.req_dropped), 32'd1);
    check("t5_lba_kept", bus_if.sd_lba, 32'h40);
    check("t5_no_rd", 32'(bus_if.sd_rd), 32'd0);
    send(SW - 200, 32'h2000 + 200, PACE);
    bus_if.sd_ack = 1'b0;
    finish_txn("t5", 100);
    check("t5_rd_cnt", 32'(rd_rises - rd0), 32'd1);
    check("t5_ack_cnt", 32'(acks - ack0), 32'd1);

    // 1180 upstream words: the extras are dropped and flagged
    begin_txn(32'h50, 1'b1, SW, 32'h3000, 1'b0);
    tick();
    bus_if.sd_ack = 1'b1;
    tick();
    check("t4_ovf_before", 32'(bus_if.err_overflow), 32'd0);
    send(SW - 1, 32'h3000, PACE);
    send(1, 32'h3000 + SW - 1, 1);
    send(4, 32'h7777, 1);
    finish_txn("t4", 100);
    check("t4_overflow", 32'(bus_if.err_overflow), 32'd1);
    // sd_ack still high: the responder must still be in DONE and ignore requests
    bus_if.cd_hps_lba = 32'h60;
    bus_if.cd_hps_req = 1'b1;
    tick();
    bus_if.cd_hps_req = 1'b0;
    check("t4_done_hold_rd", 32'(bus_if.sd_rd), 32'd0);
    check("t4_done_hold_lba", bus_if.sd_lba, 32'h50);
    bus_if.sd_ack = 1'b0;
    tick();
    tick();

    // Reset in the middle of a transfer, then a fresh sector
    begin_txn(32'h70, 1'b1, SW, 32'h4000, 1'b0);
    check("t6_idle_again", 32'(bus_if.sd_rd), 32'd1);
    tick();
    bus_if.sd_ack = 1'b1;
    tick();
    send(500, 32'h4000, PACE);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus_if.cd_hps_data_valid), 32'd0);
    check("t6_rst_data", 32'(bus_if.cd_hps_data), 32'd0);
    check("t6_rst_lba", bus_if.sd_lba, 32'd0);
    check("t6_rst_flags", 32'({bus_if.err_overflow, bus_if.err_underrun, bus_if.req_dropped}), 32'd0);
    bus_if.sd_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    begin_txn(32'h80, 1'b1, SW, 32'h5000, 1'b1);
    check("t6_sd_rd", 32'(bus_if.sd_rd), 32'd1);
    tick();
    bus_if.sd_ack = 1'b1;
    tick();
    send(SW, 32'h5000, PACE);
    bus_if.sd_ack = 1'b0;
    finish_txn("t6", 100);
    check("t6_flags", 32'({bus_if.err_overflow, bus_if.err_underrun, bus_if.req_dropped}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
